vec_issue_sequencer: RTL and testbench

VEC_ISSUE_SEQUENCER -- requirements
Module: vec_issue_sequencer

---
 rtl/vec_issue_sequencer.sv | 153 +++++++++++++++
 tb/tb_vec_issue_sequencer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_issue_sequencer.sv
// Vector issue sequencer: accepts one decoded vector instruction at a time
// and steps it through config, per-element ALU or memory element phases.
module vec_issue_sequencer #(
   parameter int VLEN = 128
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [2:0] in_alu_op,
   input  logic [4:0] in_vs1,
   input  logic [4:0] in_vs2,
   input  logic [4:0] in_vd,
   input  logic       in_is_alu,
   input  logic       in_is_ldst,
   input  logic       in_is_vlen,
   input  logic [2:0] in_vsew,
   input  logic [7:0] in_avl,
   output logic       rf_rd_en,
   output logic [4:0] rf_rd_addr1,
   output logic [4:0] rf_rd_addr2,
   output logic [3:0] rf_elem,
   output logic       alu_valid,
   output logic [2:0] alu_op,
   output logic       rf_wr_en,
   output logic [4:0] rf_wr_addr,
   output logic       mem_req_valid,
   input  logic       mem_req_ready,
   output logic [4:0] vl,
   output logic [2:0] vsew_cfg,
   output logic       vill,
   output logic       busy,
   output logic       done,
   output logic       err
);

   localparam int MAXE = VLEN / 8;

   typedef enum logic [2:0] {
      IDLE, CFG, RD, EX, WR, MEM, DONE
   } state_t;

   state_t     state, nxt;
   logic [3:0] idx, idx_nxt;
   logic [2:0] op_q, vsew_q;
   logic [4:0] vs1_q, vs2_q, vd_q;
   logic [7:0] avl_q;
   logic       alu_q, ldst_q, vlen_q;
   logic       accept, last, run_ok;
   logic [4:0] vlmax, vl_cfg;

   assign accept = in_valid && (state == IDLE);
   assign last   = ({1'b0, idx} == (vl - 5'd1));
   assign run_ok = !vill && (vl != 5'd0);

   assign vlmax  = 5'(MAXE >> vsew_q[1:0]);
   assign vl_cfg = (avl_q < {3'b000, vlmax}) ? avl_q[4:0] : vlmax;

   always_comb begin
      nxt     = state;
      idx_nxt = idx;
      case (state)
         IDLE: begin
            if (accept) begin
               idx_nxt = 4'd0;
               if (in_is_vlen)      nxt = CFG;
               else if (in_is_alu)  nxt = run_ok ? RD : DONE;
               else if (in_is_ldst) nxt = run_ok ? MEM : DONE;
               else                 nxt = DONE;
            end
         end
         CFG: nxt = DONE;
         RD:  nxt = EX;
         EX:  nxt = WR;
         WR: begin
            if (last) begin
               nxt = DONE;
            end else begin
               nxt     = RD;
               idx_nxt = idx + 4'd1;
            end
         end
         MEM: begin
            if (mem_req_ready) begin
               if (last) nxt = DONE;
               else      idx_nxt = idx + 4'd1;
            end
         end
         DONE:    nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state    <= IDLE;
         idx      <= 4'd0;
         vl       <= 5'd0;
         vsew_cfg <= 3'd0;
         vill     <= 1'b1;
         op_q     <= 3'd0;
         vsew_q   <= 3'd0;
         vs1_q    <= 5'd0;
         vs2_q    <= 5'd0;
         vd_q     <= 5'd0;
         avl_q    <= 8'd0;
         alu_q    <= 1'b0;
         ldst_q   <= 1'b0;
         vlen_q   <= 1'b0;
      end else begin
         state <= nxt;
         idx   <= idx_nxt;
         if (accept) begin
            op_q   <= in_alu_op;
            vsew_q <= in_vsew;
            vs1_q  <= in_vs1;
            vs2_q  <= in_vs2;
            vd_q   <= in_vd;
            avl_q  <= in_avl;
            alu_q  <= in_is_alu;
            ldst_q <= in_is_ldst;
            vlen_q <= in_is_vlen;
         end
         // Illegal SEW codes have bit 2 set
         if (state == CFG) begin
            if (vsew_q[2]) begin
               vill     <= 1'b1;
               vl       <= 5'd0;
               vsew_cfg <= 3'd0;
            end else begin
               vill     <= 1'b0;
               vl       <= vl_cfg;
               vsew_cfg <= vsew_q;
            end
         end
      end
   end

   assign in_ready      = (state == IDLE);
   assign busy          = (state != IDLE);
   assign rf_rd_en      = (state == RD);
   assign alu_valid     = (state == EX);
   assign rf_wr_en      = (state == WR);
   assign mem_req_valid = (state == MEM);
   assign done          = (state == DONE);
   assign err           = done && vill && (vlen_q || alu_q || ldst_q);
   assign rf_elem       = idx;
   assign rf_rd_addr1   = vs1_q;
   assign rf_rd_addr2   = vs2_q;
   assign rf_wr_addr    = vd_q;
   assign alu_op        = op_q;

endmodule

// File: tb/tb_vec_issue_sequencer.sv
// Directed bench for vec_issue_sequencer: config, ALU loop, memory
// backpressure, illegal config and mid-instruction reset.
module tb_vec_issue_sequencer;

   logic       clk = 1'b0;
   logic       rstn;
   logic       in_valid;
   logic       in_ready;
   logic [2:0] in_alu_op;
   logic [4:0] in_vs1, in_vs2, in_vd;
   logic       in_is_alu, in_is_ldst, in_is_vlen;
   logic [2:0] in_vsew;
   logic [7:0] in_avl;
   logic       rf_rd_en;
   logic [4:0] rf_rd_addr1, rf_rd_addr2;
   logic [3:0] rf_elem;
   logic       alu_valid;
   logic [2:0] alu_op;
   logic       rf_wr_en;
   logic [4:0] rf_wr_addr;
   logic       mem_req_valid;
   logic       mem_req_ready;
   logic [4:0] vl;
   logic [2:0] vsew_cfg;
   logic       vill, busy, done, err;

   int nchk  = 0;
   int npass = 0;

   always #5 clk = ~clk;

   vec_issue_sequencer #(.VLEN(128)) dut (
      .clk(clk), .rstn(rstn),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_alu_op(in_alu_op),
      .in_vs1(in_vs1), .in_vs2(in_vs2), .in_vd(in_vd),
      .in_is_alu(in_is_alu), .in_is_ldst(in_is_ldst),
      .in_is_vlen(in_is_vlen),
      .in_vsew(in_vsew), .in_avl(in_avl),
      .rf_rd_en(rf_rd_en),
      .rf_rd_addr1(rf_rd_addr1), .rf_rd_addr2(rf_rd_addr2),
      .rf_elem(rf_elem),
      .alu_valid(alu_valid), .alu_op(alu_op),
      .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .vl(vl), .vsew_cfg(vsew_cfg), .vill(vill),
      .busy(busy), .done(done), .err(err)
   );

   // Presents one instruction for exactly one accepting edge; on return
   // the bench sits just after that edge, so the next negedge is cycle 1.
   task automatic issue(input logic v, input logic a, input logic l,
                        input logic [2:0] sew, input logic [7:0] avl,
                        input logic [2:0] op, input logic [4:0] s1,
                        input logic [4:0] s2, input logic [4:0] d);
      @(negedge clk);
      in_is_vlen = v;  in_is_alu = a;  in_is_ldst = l;
      in_vsew = sew;   in_avl = avl;   in_alu_op = op;
      in_vs1 = s1;     in_vs2 = s2;    in_vd = d;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_is_vlen = 0; in_is_alu = 0; in_is_ldst = 0;
   endtask

   task automatic test_reset;
      logic [6:0] got;
      rstn = 1'b0;
      in_valid = 0; in_is_vlen = 0; in_is_alu = 0; in_is_ldst = 0;
      in_vsew = 0; in_avl = 0; in_alu_op = 0;
      in_vs1 = 0; in_vs2 = 0; in_vd = 0; mem_req_ready = 0;
      #12;
      got = {busy, done, err, rf_rd_en, alu_valid, rf_wr_en, mem_req_valid};
      nchk++;
      if (got !== 7'b0) $display("FAIL reset_strobes got=%b exp=0", got);
      else npass++;
      nchk++;
      if ({vill, vl, vsew_cfg} !== {1'b1, 5'd0, 3'd0})
         $display("FAIL reset_cfg got vill=%b vl=%0d sew=%0d exp 1/0/0",
                  vill, vl, vsew_cfg);
      else npass++;
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      nchk++;
      if (in_ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", in_ready);
      else npass++;
   endtask

   task automatic test_vlen_cfg;
      issue(1, 0, 0, 3'd2, 8'd9, 0, 0, 0, 0);
      @(negedge clk);
      nchk++;
      if ({busy, done} !== 2'b10)
         $display("FAIL vlen_cyc1 got busy/done=%b exp=10", {busy, done});
      else npass++;
      @(negedge clk);
      nchk++;
      if ({done, err, vill, vl, vsew_cfg} !== {1'b1, 1'b0, 1'b0, 5'd4, 3'd2})
         $display("FAIL vlen_done got d=%b e=%b vill=%b vl=%0d sew=%0d exp 1/0/0/4/2",
                  done, err, vill, vl, vsew_cfg);
      else npass++;
      @(negedge clk);
      nchk++;
      if ({busy, in_ready} !== 2'b01)
         $display("FAIL vlen_idle got busy/ready=%b exp=01", {busy, in_ready});
      else npass++;
   endtask

   task automatic test_alu;
      logic [8:0] got, exp;
      int ph;
      issue(0, 1, 0, 0, 0, 3'd1, 5'd3, 5'd4, 5'd5);
      for (int c = 1; c <= 13; c++) begin
         @(negedge clk);
         ph  = (c - 1) % 3;
         exp = {c <= 12 && ph == 0, c <= 12 && ph == 1, c <= 12 && ph == 2,
                c <= 12 ? 4'((c - 1) / 3) : 4'd3, c == 13, 1'b0};
         got = {rf_rd_en, alu_valid, rf_wr_en, rf_elem, done, err};
         nchk++;
         if (got !== exp)
            $display("FAIL alu_cycle%0d got=%b exp=%b", c, got, exp);
         else npass++;
         if (c == 5) begin
            nchk++;
            if ({rf_rd_addr1, rf_rd_addr2, rf_wr_addr, alu_op} !==
                {5'd3, 5'd4, 5'd5, 3'd1})
               $display("FAIL alu_addrs got a1=%0d a2=%0d wa=%0d op=%0d exp 3/4/5/1",
                        rf_rd_addr1, rf_rd_addr2, rf_wr_addr, alu_op);
            else npass++;
         end
      end
   endtask

   task automatic test_vill;
      issue(1, 0, 0, 3'd5, 8'd7, 0, 0, 0, 0);
      @(negedge clk);
      @(negedge clk);
      nchk++;
      if ({done, err, vill, vl, vsew_cfg} !== {1'b1, 1'b1, 1'b1, 5'd0, 3'd0})
         $display("FAIL vill_cfg got d=%b e=%b vill=%b vl=%0d sew=%0d exp 1/1/1/0/0",
                  done, err, vill, vl, vsew_cfg);
      else npass++;
      issue(0, 1, 0, 0, 0, 3'd2, 5'd1, 5'd2, 5'd3);
      @(negedge clk);
      nchk++;
      if ({done, err, rf_rd_en, alu_valid, rf_wr_en} !== 5'b11000)
         $display("FAIL vill_alu got=%b exp=11000",
                  {done, err, rf_rd_en, alu_valid, rf_wr_en});
      else npass++;
      @(negedge clk);
      nchk++;
      if ({busy, done, err} !== 3'b000)
         $display("FAIL vill_after got=%b exp=000", {busy, done, err});
      else npass++;
   endtask

   task automatic test_ldst;
      issue(1, 0, 0, 3'd0, 8'd2, 0, 0, 0, 0);
      @(negedge clk);
      @(negedge clk);
      nchk++;
      if ({vill, vl} !== {1'b0, 5'd2})
         $display("FAIL ldst_cfg got vill=%b vl=%0d exp 0/2", vill, vl);
      else npass++;
      mem_req_ready = 1'b0;
      issue(0, 0, 1, 0, 0, 0, 5'd7, 5'd8, 5'd9);
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         nchk++;
         if ({mem_req_valid, rf_elem, rf_rd_addr1, done} !==
             {1'b1, 4'd0, 5'd7, 1'b0})
            $display("FAIL ldst_hold%0d got v=%b e=%0d a1=%0d d=%b exp 1/0/7/0",
                     c, mem_req_valid, rf_elem, rf_rd_addr1, done);
         else npass++;
      end
      mem_req_ready = 1'b1;
      @(negedge clk);
      nchk++;
      if ({mem_req_valid, rf_elem, done} !== {1'b1, 4'd1, 1'b0})
         $display("FAIL ldst_elem1 got v=%b e=%0d d=%b exp 1/1/0",
                  mem_req_valid, rf_elem, done);
      else npass++;
      @(negedge clk);
      nchk++;
      if ({mem_req_valid, done, err} !== 3'b010)
         $display("FAIL ldst_done got=%b exp=010", {mem_req_valid, done, err});
      else npass++;
      mem_req_ready = 1'b0;
   endtask

   task automatic test_reset_mid;
      logic saw_done;
      issue(0, 1, 0, 0, 0, 3'd6, 5'd10, 5'd11, 5'd12);
      repeat (5) @(negedge clk);
      nchk++;
      if ({alu_valid, rf_elem} !== {1'b1, 4'd1})
         $display("FAIL mid_ex1 got av=%b e=%0d exp 1/1", alu_valid, rf_elem);
      else npass++;
      rstn = 1'b0;
      #1;
      nchk++;
      if ({busy, alu_valid, rf_elem, rf_wr_addr, alu_op, vl, vill} !==
          {1'b0, 1'b0, 4'd0, 5'd0, 3'd0, 5'd0, 1'b1})
         $display("FAIL mid_reset got busy=%b av=%b e=%0d wa=%0d op=%0d vl=%0d vill=%b",
                  busy, alu_valid, rf_elem, rf_wr_addr, alu_op, vl, vill);
      else npass++;
      saw_done = 1'b0;
      repeat (2) begin
         @(negedge clk);
         saw_done |= done;
      end
      rstn = 1'b1;
      repeat (4) begin
         @(negedge clk);
         saw_done |= done;
      end
      nchk++;
      if (saw_done !== 1'b0) $display("FAIL mid_no_done got=%b exp=0", saw_done);
      else npass++;
      issue(1, 0, 0, 3'd1, 8'd3, 0, 0, 0, 0);
      @(negedge clk);
      @(negedge clk);
      nchk++;
      if ({done, vill, vl, vsew_cfg} !== {1'b1, 1'b0, 5'd3, 3'd1})
         $display("FAIL mid_next got d=%b vill=%b vl=%0d sew=%0d exp 1/0/3/1",
                  done, vill, vl, vsew_cfg);
      else npass++;
   endtask

   task automatic test_back_to_back;
      // vlen and alu both set: vlen wins, so no read strobe in cycle 1
      issue(1, 1, 0, 3'd3, 8'd0, 3'd1, 5'd1, 5'd1, 5'd1);
      @(negedge clk);
      nchk++;
      if ({busy, rf_rd_en, done} !== 3'b100)
         $display("FAIL prio_cyc1 got=%b exp=100", {busy, rf_rd_en, done});
      else npass++;
      @(negedge clk);
      nchk++;
      if ({done, vl, vsew_cfg, vill} !== {1'b1, 5'd0, 3'd3, 1'b0})
         $display("FAIL prio_done got d=%b vl=%0d sew=%0d vill=%b exp 1/0/3/0",
                  done, vl, vsew_cfg, vill);
      else npass++;
      issue(0, 1, 0, 0, 0, 3'd2, 5'd2, 5'd2, 5'd2);
      @(negedge clk);
      nchk++;
      if ({done, err, rf_rd_en, alu_valid, rf_wr_en} !== 5'b10000)
         $display("FAIL vl0_alu got=%b exp=10000",
                  {done, err, rf_rd_en, alu_valid, rf_wr_en});
      else npass++;
      issue(0, 0, 0, 3'd1, 8'd5, 0, 0, 0, 0);
      @(negedge clk);
      nchk++;
      if ({done, err, vl, vsew_cfg} !== {1'b1, 1'b0, 5'd0, 3'd3})
         $display("FAIL noflag got d=%b e=%b vl=%0d sew=%0d exp 1/0/0/3",
                  done, err, vl, vsew_cfg);
      else npass++;
      @(negedge clk);
      nchk++;
      if ({busy, in_ready} !== 2'b01)
         $display("FAIL b2b_idle got=%b exp=01", {busy, in_ready});
      else npass++;
   endtask

   initial begin
      test_reset;
      test_vlen_cfg;
      test_alu;
      test_vill;
      test_ldst;
      test_reset_mid;
      test_back_to_back;
      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end

endmodule
